// File: rtl/oka_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oka_pkg
// Description : Shared types and constants for the OKA GF(2)[x] multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package oka_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_E = 3'd1,
        MUL_O = 3'd2,
        MUL_M = 3'd3,
        COMB  = 3'd4,
        DONE  = 3'd5
    } oka_state_t;

    // Low-order terms of the NIST binary-field reduction polynomials
    localparam logic [162:0] C_POLY_B163 = 163'h0C9;
    localparam logic [232:0] C_POLY_B233 = (233'd1 << 74) | 233'd1;
    localparam logic [282:0] C_POLY_B283 = 283'h10A1;

    function automatic int half_width(input int n);
        return (n + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clmul_comb.sv
`default_nettype none
// ============================================================================
// Module      : clmul_comb
// Description : W-by-W combinational carry-less (GF(2)[x]) multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module clmul_comb #(
    parameter int W = 82
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-2:0] o_p
);

    localparam int PW = 2 * W - 1;

    always_comb begin
        o_p = '0;
        for (int i = 0; i < W; i++) begin
            if (i_b[i]) begin
                o_p = o_p ^ (PW'(i_a) << i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/oka_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : oka_mult_seq
// Description : Sequential overlap-free Karatsuba multiplier over GF(2)[x]
//               with optional reduction modulo x^N + POLY.
// Revision    : 1.0 - initial release
// ============================================================================
module oka_mult_seq
    import oka_pkg::*;
#(
    parameter int             N    = 163,
    parameter logic [N-1:0]   POLY = N'(C_POLY_B163)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           reduce_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y
);

    localparam int H  = half_width(N);
    localparam int YW = 2 * N - 1;

    oka_state_t     r_state, w_state_nxt;
    logic [H-1:0]   w_a_e, w_a_o, w_b_e, w_b_o;
    logic [H-1:0]   r_a_e, r_a_o, r_b_e, r_b_o;
    logic [H-1:0]   w_op_a, w_op_b;
    logic           r_reduce;
    logic [2*H-2:0] w_p, w_m;
    logic [2*H-2:0] r_p_e, r_p_o, r_p_m;
    logic [4*H-2:0] w_full;
    logic [YW-1:0]  w_prod, w_red, r_y;

    // Even/odd coefficient split; the odd half is zero-padded for odd N
    for (genvar i = 0; i < H; i++) begin : g_split
        assign w_a_e[i] = a[2*i];
        assign w_b_e[i] = b[2*i];
        if (2 * i + 1 < N) begin : g_odd
            assign w_a_o[i] = a[2*i+1];
            assign w_b_o[i] = b[2*i+1];
        end else begin : g_pad
            assign w_a_o[i] = 1'b0;
            assign w_b_o[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = MUL_E;
                end
            end
            MUL_E: w_state_nxt = MUL_O;
            MUL_O: w_state_nxt = MUL_M;
            MUL_M: w_state_nxt = COMB;
            COMB:  w_state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand select for the single shared half-width multiplier
    always_comb begin
        w_op_a = r_a_e;
        w_op_b = r_b_e;
        case (r_state)
            MUL_O: begin
                w_op_a = r_a_o;
                w_op_b = r_b_o;
            end
            MUL_M: begin
                w_op_a = r_a_e ^ r_a_o;
                w_op_b = r_b_e ^ r_b_o;
            end
            default: ;
        endcase
    end

    clmul_comb #(.W(H)) u_clmul (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_p (w_p)
    );

    assign w_m = r_p_e ^ r_p_o ^ r_p_m;

    // Overlap-free recombination: even result bits from p_e and shifted p_o,
    // odd result bits straight from the middle term
    assign w_full[0]       = r_p_e[0];
    assign w_full[4*H-2]   = r_p_o[2*H-2];
    for (genvar i = 0; i < 2 * H - 1; i++) begin : g_recomb
        assign w_full[2*i+1] = w_m[i];
        if (i > 0) begin : g_even
            assign w_full[2*i] = r_p_e[i] ^ r_p_o[i-1];
        end
    end

    // For odd N the two top recombination bits are identically zero
    if (4 * H - 1 > YW) begin : g_trunc
        logic [1:0] w_unused_top;
        assign w_prod       = w_full[YW-1:0];
        assign w_unused_top = w_full[4*H-2:4*H-3];
    end else begin : g_exact
        assign w_prod = w_full;
    end

    always_comb begin
        w_red = w_prod;
        for (int i = YW - 1; i >= N; i--) begin
            if (w_red[i]) begin
                w_red    = w_red ^ (YW'(POLY) << (i - N));
                w_red[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_e    <= '0;
            r_a_o    <= '0;
            r_b_e    <= '0;
            r_b_o    <= '0;
            r_reduce <= 1'b0;
            r_p_e    <= '0;
            r_p_o    <= '0;
            r_p_m    <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_e    <= w_a_e;
                        r_a_o    <= w_a_o;
                        r_b_e    <= w_b_e;
                        r_b_o    <= w_b_o;
                        r_reduce <= reduce_en;
                    end
                end
                MUL_E: r_p_e <= w_p;
                MUL_O: r_p_o <= w_p;
                MUL_M: r_p_m <= w_p;
                COMB:  r_y   <= r_reduce ? w_red : w_prod;
                default: ;
            endcase
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_oka_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_oka_mult_seq
// Description : Self-checking bench for oka_mult_seq (N=163 and N=7 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oka_mult_seq;

    localparam int           N       = 163;
    localparam int           YW      = 2 * N - 1;
    localparam logic [N-1:0] POLY163 = 163'h0C9;
    localparam logic [6:0]   POLY7   = 7'h03;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, reduce_en, out_valid, out_ready;
    logic [N-1:0]   a, b;
    logic [YW-1:0]  y;
    logic           iv7, ir7, red7, ov7, or7;
    logic [6:0]     a7, b7;
    logic [12:0]    y7;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    oka_mult_seq #(.N(N)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .reduce_en(reduce_en), .out_valid(out_valid),
        .out_ready(out_ready), .y(y)
    );

    oka_mult_seq #(.N(7), .POLY(POLY7)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7),
        .a(a7), .b(b7), .reduce_en(red7), .out_valid(ov7),
        .out_ready(or7), .y(y7)
    );

    task automatic chk(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Polynomial product, then remainder by long division with f = x^n + poly
    function automatic logic [YW-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] z,
                                              input int n, input logic [N-1:0] poly, input bit red);
        logic [2*N-1:0] p;
        logic [2*N-1:0] f;
        p = '0;
        for (int i = 0; i < n; i++)
            if (x[i]) p = p ^ ((2*N)'(z) << i);
        if (red) begin
            f = (2*N)'(poly);
            f[n] = 1'b1;
            for (int d = 2 * n - 2; d >= n; d--)
                if (p[d]) p = p ^ (f << (d - n));
        end
        return p[YW-1:0];
    endfunction

    function automatic logic [N-1:0] rnd163();
        logic [191:0] t;
        for (int w = 0; w < 6; w++) t[w*32 +: 32] = $urandom;
        return t[N-1:0];
    endfunction

    task automatic run_op(input bit s7, input logic [N-1:0] x, input logic [N-1:0] z,
                          input bit red, output logic [YW-1:0] yo, output int lat);
        if (s7) begin
            a7 = x[6:0]; b7 = z[6:0]; red7 = red; iv7 = 1'b1;
        end else begin
            a = x; b = z; reduce_en = red; in_valid = 1'b1;
        end
        tick();
        in_valid = 1'b0; iv7 = 1'b0;
        a = ~a; b = ~b; a7 = ~a7; b7 = ~b7;
        reduce_en = ~reduce_en; red7 = ~red7;
        lat = 0;
        while (((s7 ? ov7 : out_valid) !== 1'b1) && lat < 20) begin
            tick();
            lat++;
        end
        yo = s7 ? YW'(y7) : y;
        out_ready = 1'b1; or7 = 1'b1;
        tick();
        out_ready = 1'b0; or7 = 1'b0;
    endtask

    initial begin
        logic [YW-1:0] yo, exp;
        logic [N-1:0]  x, z;
        bit            red;
        bit            bad;
        int            lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; reduce_en = 1'b0;
        a = '0; b = '0; iv7 = 1'b0; or7 = 1'b0; red7 = 1'b0; a7 = '0; b7 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y7", YW'(y7), 0);

        // a=1, b=1 with cycle-by-cycle handshake observation
        a = 1; b = 1; reduce_en = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("busy_in_ready", in_ready, 0);
            chk("lat_out_valid", out_valid, (e == 4) ? 1 : 0);
        end
        chk("one_y", y, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);

        run_op(0, 3, 3, 0, yo, lat);
        chk("three_sq", yo, 5);
        chk("three_lat", lat, 4);

        x = '0; x[162] = 1'b1;
        exp = '0; exp[324] = 1'b1;
        run_op(0, x, x, 0, yo, lat);
        chk("top_sq", yo, exp);

        run_op(0, x, 2, 1, yo, lat);
        chk("red_x163", yo, 'hC9);
        exp = '0; exp[163] = 1'b1;
        run_op(0, x, 2, 0, yo, lat);
        chk("full_x163", yo, exp);

        z = rnd163();
        run_op(0, '0, z, 1, yo, lat);
        chk("zero_op", yo, 0);
        run_op(0, 1, z, 0, yo, lat);
        chk("unit_op", yo, YW'(z));

        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_out_ready", in_ready, 1);

        // Back-pressure: result held, new requests ignored
        x = rnd163(); z = rnd163();
        exp = ref_mul(x, z, N, POLY163, 1'b1);
        a = x; b = z; reduce_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_lat", lat, 4);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; a = rnd163(); b = rnd163(); reduce_en = 1'b0;
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_y", y, exp);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        tick();
        chk("bp_idle_stays", in_ready, 1);

        // Reset while in MUL_O discards the operation
        a = rnd163(); b = rnd163(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", y, 0);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        chk("mid_rst_quiet", bad, 0);
        x = rnd163(); z = rnd163();
        run_op(0, x, z, 0, yo, lat);
        chk("post_rst_y", yo, ref_mul(x, z, N, POLY163, 1'b0));
        chk("post_rst_lat", lat, 4);

        // Odd-N padding path on the N=7 instance
        run_op(1, 'h7F, 'h7F, 0, yo, lat);
        chk("n7_sq", yo, 'h1555);
        chk("n7_lat", lat, 4);
        for (int n = 0; n < 200; n++) begin
            x = N'($urandom_range(0, 127));
            z = N'($urandom_range(0, 127));
            red = 1'($urandom_range(0, 1));
            run_op(1, x, z, red, yo, lat);
            chk("n7_rnd_y", yo, ref_mul(x, z, 7, N'(POLY7), red));
        end

        for (int n = 0; n < 9800; n++) begin
            x = rnd163(); z = rnd163();
            red = 1'($urandom_range(0, 1));
            if (n % 16 == 0) x = N'(1) << $urandom_range(0, N - 1);
            run_op(0, x, z, red, yo, lat);
            chk("rnd_y", yo, ref_mul(x, z, N, POLY163, red));
            chk("rnd_lat", lat, 4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
